inst_fetch_unit: RTL

Instruction fetch stage directly upstream of the instruction decoders (R/I/S/B/U/J). Owns the program counter, issues word-aligned requests to instruction memory over a valid/ready request channel, buffers in-order responses in a small prefetch FIFO, and presents `instr_word`/`instr_pc` to decode with a valid/ready handshake. A redirect (branch/jump from execute) flushes buffered and in-flight instructions and restarts fetch at a new PC.

---
 rtl/inst_fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned memory requests under a credit limit,
// buffers in-order responses in a small prefetch FIFO and handles redirects by dropping stale responses.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_word,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t             state_reg, state_next;
    logic [31:0]        fetch_pc_reg, fetch_pc_next;
    logic [31:0]        resp_pc_reg, resp_pc_next;
    logic [CNT_W-1:0]   inflight_reg, inflight_next;
    logic [CNT_W-1:0]   drop_cnt_reg, drop_cnt_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [31:0]        fifo_pc_reg   [FIFO_DEPTH];
    logic [31:0]        fifo_word_reg [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] entry_we;

    logic               req_hs, resp_keep, resp_drop, pop;
    logic [CNT_W-1:0]   credit_used, drop_redirect;
    logic [31:0]        redirect_base;

    assign redirect_base = redirect_pc & ~32'h3;
    // Every slot already promised (pending, stale or buffered) counts against the FIFO capacity.
    assign credit_used   = inflight_reg + drop_cnt_reg + count_reg;
    assign req_hs        = imem_req_valid && imem_req_ready;
    assign resp_keep     = imem_resp_valid && !redirect_valid && (drop_cnt_reg == '0);
    assign resp_drop     = imem_resp_valid && !redirect_valid && (drop_cnt_reg != '0);
    assign pop           = instr_valid && instr_ready;
    assign drop_redirect = inflight_reg + drop_cnt_reg + CNT_W'(req_hs) - CNT_W'(imem_resp_valid);

    assign imem_req_addr = fetch_pc_reg;
    assign instr_valid   = (count_reg != '0);
    assign instr_word    = fifo_word_reg[rd_ptr_reg];
    assign instr_pc      = fifo_pc_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            inflight_reg <= '0;
            drop_cnt_reg <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            resp_pc_reg  <= resp_pc_next;
            inflight_reg <= inflight_next;
            drop_cnt_reg <= drop_cnt_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        resp_pc_next  = resp_pc_reg;
        inflight_next = inflight_reg + CNT_W'(req_hs) - CNT_W'(resp_keep);
        drop_cnt_next = drop_cnt_reg - CNT_W'(resp_drop);
        count_next    = count_reg + CNT_W'(resp_keep) - CNT_W'(pop);
        wr_ptr_next   = wr_ptr_reg + PTR_W'(resp_keep);
        rd_ptr_next   = rd_ptr_reg + PTR_W'(pop);
        if (req_hs) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
        if (resp_keep) begin
            resp_pc_next = resp_pc_reg + 32'd4;
        end
        // Everything accepted so far becomes stale; the FIFO is discarded wholesale.
        if (redirect_valid) begin
            fetch_pc_next = redirect_base;
            resp_pc_next  = redirect_base;
            inflight_next = '0;
            drop_cnt_next = drop_redirect;
            count_next    = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            state_next = (drop_redirect != '0) ? FLUSH : RUN;
        end else begin
            case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     state_next = RUN;
                FLUSH:   state_next = (drop_cnt_next == '0) ? RUN : FLUSH;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req_valid = 1'b0;
        if (state_reg == RUN && credit_used < CNT_W'(FIFO_DEPTH)) begin
            imem_req_valid = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = resp_keep && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Storage is reset so the head outputs read zero while nothing has been fetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_reg[i]   <= '0;
                fifo_word_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (entry_we[i]) begin
                    fifo_pc_reg[i]   <= resp_pc_reg;
                    fifo_word_reg[i] <= imem_resp_data;
                end
            end
        end
    end

endmodule
